// File: rtl/pin_array_seq_ctrl_pkg.sv
// Shared types and constants for the four-lane pin array sequencing controller.
// Lane count is fixed at four, so a lane index is always two bits wide.
package pin_array_ctrl_pkg;

    localparam int NLANE    = 4;
    localparam int IDX_W    = 2;
    localparam int SETTLE_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        SAMPLE  = 2'd2,
        RELEASE = 2'd3
    } pa_state_t;

    function automatic logic [NLANE-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NLANE-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/pin_array_seq_ctrl_if.sv
// Requester/controller bundle: lane requests and configuration in, lane enables,
// sample strobe and completion/abort pulses out.
interface pin_array_seq_ctrl_if;
    import pin_array_ctrl_pkg::*;

    logic [NLANE-1:0]    req;
    logic [NLANE-1:0]    lane_mask;
    logic [SETTLE_W-1:0] settle_cyc;
    logic [NLANE-1:0]    lane_en;
    logic                sample;
    logic [NLANE-1:0]    done;
    logic                abort;
    logic                busy;
    logic [IDX_W-1:0]    cur_idx;

    modport master (
        output req, lane_mask, settle_cyc,
        input  lane_en, sample, done, abort, busy, cur_idx
    );

    modport slave (
        input  req, lane_mask, settle_cyc,
        output lane_en, sample, done, abort, busy, cur_idx
    );

endinterface

// File: rtl/pin_array_seq_ctrl_arb.sv
// Combinational round-robin pick: first eligible lane at or above ptr, wrapping
// modulo the lane count.
module pin_array_rr_arb
    import pin_array_ctrl_pkg::*;
(
    input  logic [NLANE-1:0] elig,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // rot[k] is the eligibility of lane ptr+k, so the lowest set bit wins.
    logic [NLANE-1:0] rot;

    generate
        for (genvar gi = 0; gi < NLANE; gi++) begin : g_rot
            assign rot[gi] = elig[ptr + IDX_W'(gi)];
        end
    endgenerate

    always_comb begin
        valid = |rot;
        idx   = ptr;
        for (int k = NLANE - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx = ptr + IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/pin_array_seq_ctrl.sv
// Lane sequencing FSM: grant one lane round-robin, hold its enable through a
// settle interval, strobe the shared stage, then release before the next grant.
module pin_array_seq_ctrl
    import pin_array_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    pin_array_seq_ctrl_if.slave bus
);

    pa_state_t           state_q,   state_d;
    logic [SETTLE_W-1:0] cnt_q,     cnt_d;
    logic [IDX_W-1:0]    ptr_q,     ptr_d;
    logic [IDX_W-1:0]    cur_idx_q, cur_idx_d;
    logic [NLANE-1:0]    lane_en_q, lane_en_d;
    logic [NLANE-1:0]    done_q,    done_d;
    logic                sample_q,  sample_d;
    logic                abort_q,   abort_d;
    logic                busy_q,    busy_d;

    logic                arb_valid;
    logic [IDX_W-1:0]    arb_idx;
    logic                cur_held;

    pin_array_rr_arb u_arb (
        .elig  (bus.req & bus.lane_mask),
        .ptr   (ptr_q),
        .valid (arb_valid),
        .idx   (arb_idx)
    );

    assign cur_held = bus.req[cur_idx_q] & bus.lane_mask[cur_idx_q];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        cur_idx_d = cur_idx_q;
        abort_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d   = SETTLE;
                    cur_idx_d = arb_idx;
                    cnt_d     = (bus.settle_cyc == '0) ? SETTLE_W'(1) : bus.settle_cyc;
                end
            end
            SETTLE: begin
                // Withdrawal wins over a settle count that happens to expire now.
                if (!cur_held) begin
                    state_d = RELEASE;
                    abort_d = 1'b1;
                end else if (cnt_q <= SETTLE_W'(1)) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SAMPLE: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                state_d = IDLE;
                ptr_d   = cur_idx_q + IDX_W'(1);
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are a registered image of the state being entered.
        lane_en_d = (state_d == SETTLE || state_d == SAMPLE) ? idx_to_onehot(cur_idx_d) : '0;
        sample_d  = (state_d == SAMPLE);
        done_d    = sample_d ? idx_to_onehot(cur_idx_d) : '0;
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            cur_idx_q <= '0;
            lane_en_q <= '0;
            done_q    <= '0;
            sample_q  <= 1'b0;
            abort_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            cur_idx_q <= cur_idx_d;
            lane_en_q <= lane_en_d;
            done_q    <= done_d;
            sample_q  <= sample_d;
            abort_q   <= abort_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.lane_en = lane_en_q;
    assign bus.sample  = sample_q;
    assign bus.done    = done_q;
    assign bus.abort   = abort_q;
    assign bus.busy    = busy_q;
    assign bus.cur_idx = cur_idx_q;

endmodule

// File: tb/tb_pin_array_seq_ctrl.sv
// Bench for pin_array_seq_ctrl: timeline reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_pin_array_seq_ctrl;
    import pin_array_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pin_array_seq_ctrl_if bus();

    pin_array_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: position p counts cycles since the grant edge. p in [0,n-1] settle,
    // p==n sample, p==n+1 release; an abort jumps straight to p==n+1.
    typedef struct {
        bit active;
        int lane;
        int n;
        int p;
        bit ab;
        int ptr;
        int cur;
    } model_t;

    model_t m;

    function automatic model_t model_step(model_t s, logic [3:0] rq, logic [3:0] mk, logic [3:0] st);
        model_t r;
        logic [3:0] el;
        int idx;
        r   = s;
        el  = rq & mk;
        idx = -1;
        if (!r.active) begin
            for (int k = 0; k < 4; k++) begin
                if (idx < 0 && el[(r.ptr + k) % 4]) idx = (r.ptr + k) % 4;
            end
            if (idx >= 0) begin
                r.active = 1'b1;
                r.lane   = idx;
                r.cur    = idx;
                r.n      = (st == 4'd0) ? 1 : int'(st);
                r.p      = 0;
                r.ab     = 1'b0;
            end
        end else if (r.p < r.n && !(rq[r.lane] && mk[r.lane])) begin
            r.p  = r.n + 1;
            r.ab = 1'b1;
        end else if (r.p == r.n + 1) begin
            r.active = 1'b0;
            r.ptr    = (r.lane + 1) % 4;
        end else begin
            r.p = r.p + 1;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{default: 0};
        else        m <= model_step(m, bus.req, bus.lane_mask, bus.settle_cyc);
    end

    // Observation log shared with the directed checks.
    int         grant_lane[$];
    int         grant_cyc[$];
    int         en_len[$];
    int         sample_cyc[$];
    int         abort_n = 0;
    int         cyc = 0;
    int         run = 0;
    logic [3:0] prev_en = '0;
    logic [3:0] done_seen = '0;

    always @(negedge clk) begin
        logic [3:0] e_en;
        logic [3:0] e_done;
        logic       e_s;
        logic       e_a;
        if (rst_n) begin
            e_en   = (m.active && m.p <= m.n) ? 4'(1 << m.lane) : 4'd0;
            e_s    = m.active && m.p == m.n && !m.ab;
            e_done = e_s ? 4'(1 << m.lane) : 4'd0;
            e_a    = m.active && m.p == m.n + 1 && m.ab;
            total++;
            if ({bus.lane_en, bus.sample, bus.done, bus.abort, bus.busy, bus.cur_idx} !==
                {e_en, e_s, e_done, e_a, m.active, 2'(m.cur)}) begin
                bad++;
                $display("FAIL cycle_cmp t=%0t got en=%b s=%b d=%b a=%b b=%b i=%0d want en=%b s=%b d=%b a=%b b=%b i=%0d",
                         $time, bus.lane_en, bus.sample, bus.done, bus.abort, bus.busy, bus.cur_idx,
                         e_en, e_s, e_done, e_a, m.active, m.cur);
            end
            total++;
            if ($countones(bus.lane_en) > 1) begin
                bad++;
                $display("FAIL onehot t=%0t got lane_en=%b want at most one bit", $time, bus.lane_en);
            end
            if (bus.lane_en != 0 && prev_en == 0) begin
                grant_lane.push_back(int'(bus.cur_idx));
                grant_cyc.push_back(cyc);
                run = 0;
            end
            if (bus.lane_en != 0) run++;
            if (bus.lane_en == 0 && prev_en != 0) en_len.push_back(run);
            if (bus.sample) sample_cyc.push_back(cyc);
            if (bus.abort) abort_n++;
            done_seen = bus.done;
            prev_en   = bus.lane_en;
        end else begin
            prev_en   = '0;
            done_seen = '0;
        end
        cyc++;
    end

    bit         rereq = 1'b0;
    logic [3:0] raise_pending = '0;

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    function automatic int qget(int q[$], int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic clear_log();
        grant_lane.delete();
        grant_cyc.delete();
        en_len.delete();
        sample_cyc.delete();
        abort_n = 0;
    endtask

    // One cycle of stimulus; requesters drop req in the cycle after done.
    task automatic step();
        @(posedge clk);
        #2;
        for (int i = 0; i < 4; i++) begin
            if (done_seen[i]) begin
                bus.req[i] = 1'b0;
                if (rereq) raise_pending[i] = 1'b1;
            end else if (raise_pending[i]) begin
                bus.req[i]       = 1'b1;
                raise_pending[i] = 1'b0;
            end
        end
    endtask

    task automatic run_cycles(int n);
        repeat (n) step();
    endtask

    task automatic wait_grant(int want, int budget, string nm);
        int k;
        k = 0;
        while (grant_lane.size() < want && k < budget) begin
            step();
            @(negedge clk);
            #1;
            k++;
        end
        if (grant_lane.size() < want) begin
            total++;
            bad++;
            $display("FAIL %s_timeout got grants=%0d want=%0d", nm, grant_lane.size(), want);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        raise_pending = '0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt;
        bus.req        = '0;
        bus.lane_mask  = 4'hF;
        bus.settle_cyc = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lane_en", int'(bus.lane_en), 0);
        chk("rst_sample",  int'(bus.sample),  0);
        chk("rst_done",    int'(bus.done),    0);
        chk("rst_abort",   int'(bus.abort),   0);
        chk("rst_busy",    int'(bus.busy),    0);
        chk("rst_cur_idx", int'(bus.cur_idx), 0);
        #3;
        rst_n = 1'b1;

        // Single request on lane 2 with settle 3.
        clear_log();
        step();
        bus.req        = 4'b0100;
        bus.settle_cyc = 4'd3;
        wait_grant(1, 20, "single");
        run_cycles(8);
        chk("single_idx",    qget(grant_lane, 0), 2);
        chk("single_en_len", qget(en_len, 0), 4);
        chk("single_sample", qget(sample_cyc, 0) - qget(grant_cyc, 0), 3);
        chk("single_ngrant", grant_lane.size(), 1);

        // All four continuously, from reset, settle 2.
        do_reset();
        clear_log();
        rereq          = 1'b1;
        bus.settle_cyc = 4'd2;
        bus.req        = 4'hF;
        wait_grant(5, 60, "rr");
        for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), qget(grant_lane, i), i % 4);
        for (int i = 0; i < 4; i++) chk($sformatf("rr_period%0d", i), qget(grant_cyc, i + 1) - qget(grant_cyc, i), 5);
        rereq   = 1'b0;
        bus.req = '0;
        raise_pending = '0;
        run_cycles(8);

        // Settle 0 and settle 1 give identical timing.
        for (int s = 0; s < 2; s++) begin
            clear_log();
            bus.settle_cyc = 4'(s);
            bus.req        = 4'b0001;
            wait_grant(1, 20, "settle01");
            run_cycles(6);
            chk($sformatf("settle%0d_en_len", s), qget(en_len, 0), 2);
            chk($sformatf("settle%0d_sample", s), qget(sample_cyc, 0) - qget(grant_cyc, 0), 1);
        end

        // Withdrawal of lane 1 mid-settle, next grant goes to lane 2.
        do_reset();
        clear_log();
        bus.settle_cyc = 4'd8;
        bus.req        = 4'b0010;
        wait_grant(1, 20, "wd");
        run_cycles(3);
        bus.req = 4'b1101;
        wait_grant(2, 20, "wd2");
        run_cycles(2);
        chk("wd_first", qget(grant_lane, 0), 1);
        chk("wd_en_len", qget(en_len, 0), 4);
        chk("wd_abort", abort_n, 1);
        cnt = 0;
        foreach (sample_cyc[i]) if (sample_cyc[i] < qget(grant_cyc, 1)) cnt++;
        chk("wd_no_sample", cnt, 0);
        chk("wd_next", qget(grant_lane, 1), 2);
        bus.req = '0;
        run_cycles(14);

        // Masked lanes 0 and 2.
        do_reset();
        clear_log();
        rereq          = 1'b1;
        bus.settle_cyc = 4'd1;
        bus.lane_mask  = 4'b1010;
        bus.req        = 4'hF;
        wait_grant(3, 40, "mask");
        chk("mask_g0", qget(grant_lane, 0), 1);
        chk("mask_g1", qget(grant_lane, 1), 3);
        chk("mask_g2", qget(grant_lane, 2), 1);
        rereq = 1'b0;
        bus.req = '0;
        raise_pending = '0;
        bus.lane_mask = 4'hF;
        run_cycles(8);

        // Serve lane 2 so ptr sits at 3, then reset during the next settle.
        bus.req = 4'b0100;
        run_cycles(8);
        clear_log();
        bus.settle_cyc = 4'd8;
        bus.req        = 4'b0100;
        wait_grant(1, 20, "rstmid");
        step();
        bus.req = 4'b1110;
        @(posedge clk);
        #3;
        chk("rstmid_pre_en", int'(bus.lane_en), 4);
        rst_n = 1'b0;
        #1;
        chk("rstmid_en",     int'(bus.lane_en), 0);
        chk("rstmid_sample", int'(bus.sample),  0);
        chk("rstmid_busy",   int'(bus.busy),    0);
        bus.req = 4'b1010;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        clear_log();
        wait_grant(1, 20, "rstpost");
        chk("rstpost_first", qget(grant_lane, 0), 1);
        bus.req = '0;
        run_cycles(14);

        // Randomized traffic, model compared every cycle.
        for (int c = 0; c < 600; c++) begin
            step();
            if ($urandom_range(0, 7) == 0) bus.settle_cyc = 4'($urandom_range(0, 5));
            if ($urandom_range(0, 15) == 0) bus.lane_mask = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) begin
                if (bus.req[i]) begin
                    if ($urandom_range(0, 9) == 0) bus.req[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    bus.req[i] = 1'b1;
                end
            end
        end
        run_cycles(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
